// File: rtl/icache_setassoc.sv
// N-way set-associative instruction cache with tree pseudo-LRU replacement and a walking flush.
// One word per cycle on a hit; a miss fetches a whole line from L2 and refills the victim way.
module icache_setassoc #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned BlockWords = 8,
  parameter int unsigned Sets       = 128,
  parameter int unsigned Ways       = 2,
  parameter logic [AddrWidth-1:0] AddrInit = 32'h0001_0000,
  localparam int unsigned OffW  = $clog2(BlockWords * 4),
  localparam int unsigned LineW = BlockWords * DataWidth
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [AddrWidth-1:0]      addr_i,
  input  logic                      addr_valid_i,
  output logic [DataWidth-1:0]      data_o,
  output logic                      cache_ready_o,
  output logic                      addr_to_l2_valid_o,
  output logic [AddrWidth-OffW-1:0] addr_to_l2_o,
  input  logic [LineW-1:0]          data_from_l2_i,
  input  logic                      data_from_l2_valid_i,
  output logic [AddrWidth-1:0]      addr_out_o
);

  localparam int unsigned IdxW  = $clog2(Sets);
  localparam int unsigned TagW  = AddrWidth - IdxW - OffW;
  localparam int unsigned WordW = OffW - 2;
  localparam int unsigned WayW  = (Ways > 1) ? $clog2(Ways) : 1;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StFill, StFlush} state_e;

  state_e                   state_q;
  logic [AddrWidth-1:0]     addr_q;
  logic [WayW-1:0]          victim_q;
  logic                     flush_pend_q;
  logic [IdxW-1:0]          flush_idx_q;
  logic                     l2_valid_q;
  logic [AddrWidth-OffW-1:0] l2_addr_q;
  logic [LineW-1:0]         fill_line_q;

  logic [Ways-1:0]          valid_q    [Sets];
  logic [2:0]               plru_q     [Sets];
  logic [TagW-1:0]          tag_q      [Ways][Sets];
  logic [LineW-1:0]         line_mem_q [Ways][Sets];

  logic [IdxW-1:0]  idx;
  logic [TagW-1:0]  tag;
  logic [WordW-1:0] word;
  logic             hit;
  logic [WayW-1:0]  hit_way;
  logic [WayW-1:0]  victim;
  logic             found_free;

  // Tree bits: [0] root (0 = evict left pair), [1] left pair, [2] right pair.
  function automatic logic [WayW-1:0] plru_victim(input logic [2:0] b);
    logic [1:0] v;
    if (Ways == 4)      v = b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
    else if (Ways == 2) v = {1'b0, b[0]};
    else                v = 2'b00;
    return v[WayW-1:0];
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
    logic [2:0] n;
    n = b;
    if (Ways == 4) begin
      n[0] = ~w[1];
      if (w[1]) n[2] = ~w[0];
      else      n[1] = ~w[0];
    end else if (Ways == 2) begin
      n[0] = ~w[0];
    end
    return n;
  endfunction

  assign idx  = addr_q[OffW +: IdxW];
  assign tag  = addr_q[AddrWidth-1 -: TagW];
  assign word = addr_q[OffW-1:2];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < Ways; w++) begin
      if (valid_q[idx][w] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
    end
  end

  always_comb begin
    victim     = plru_victim(plru_q[idx]);
    found_free = 1'b0;
    for (int unsigned w = 0; w < Ways; w++) begin
      if (!found_free && !valid_q[idx][w]) begin
        victim     = WayW'(w);
        found_free = 1'b1;
      end
    end
  end

  assign cache_ready_o      = (state_q == StIdle) && hit;
  assign data_o             = line_mem_q[hit_way][idx][word*DataWidth +: DataWidth];
  assign addr_out_o         = addr_q;
  assign addr_to_l2_valid_o = l2_valid_q;
  assign addr_to_l2_o       = l2_addr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      addr_q       <= AddrInit;
      victim_q     <= '0;
      flush_pend_q <= 1'b0;
      flush_idx_q  <= '0;
      l2_valid_q   <= 1'b0;
      l2_addr_q    <= '0;
      fill_line_q  <= '0;
      for (int unsigned s = 0; s < Sets; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      l2_valid_q <= 1'b0;
      if (cache_ready_o && addr_valid_i) begin
        addr_q      <= addr_i;
        plru_q[idx] <= plru_touch(plru_q[idx], 2'(hit_way));
      end
      unique case (state_q)
        StIdle: begin
          if (flush_i) begin
            state_q     <= StFlush;
            flush_idx_q <= '0;
          end else if (!hit) begin
            state_q    <= StReq;
            victim_q   <= victim;
            l2_valid_q <= 1'b1;
            l2_addr_q  <= addr_q[AddrWidth-1:OffW];
          end
        end
        StReq: begin
          state_q      <= StWait;
          flush_pend_q <= flush_pend_q | flush_i;
        end
        StWait: begin
          flush_pend_q <= flush_pend_q | flush_i;
          if (data_from_l2_valid_i) begin
            fill_line_q <= data_from_l2_i;
            state_q     <= StFill;
          end
        end
        StFill: begin
          valid_q[idx][victim_q] <= 1'b1;
          plru_q[idx]            <= plru_touch(plru_q[idx], 2'(victim_q));
          flush_pend_q           <= 1'b0;
          // The refill always lands before a pending flush wipes it.
          if (flush_pend_q || flush_i) begin
            state_q     <= StFlush;
            flush_idx_q <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        StFlush: begin
          valid_q[flush_idx_q] <= '0;
          flush_idx_q          <= flush_idx_q + 1'b1;
          if (flush_idx_q == IdxW'(Sets - 1)) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Line and tag storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk_i) begin
    if (state_q == StFill) begin
      tag_q[victim_q][idx]      <= tag;
      line_mem_q[victim_q][idx] <= fill_line_q;
    end
  end

endmodule
